serial_adder_ctrl: RTL and testbench

//  Bit-serial WIDTH-bit adder datapath and controller feeding the one_bit full-adder cell.
//  - Accepts two operands and a carry-in via a valid/ready handshake.
//  - Streams one bit pair per clock, LSB first, into the cell and registers the cell's carry.
//  - Assembles sum bits in a shift register and presents {cout,sum} via a valid/ready handshake.
//  - Trades WIDTH cycles of latency for a single adder cell.

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_adder_ctrl_one_bit.sv | 15 +
 rtl/serial_adder_ctrl.sv | 116 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t : controller states (IDLE/SHIFT/DONE)
//   CNT_W   : bit-counter width for a given operand width, never below 1
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int CNT_W(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_one_bit.sv
// Single full-adder cell; the only arithmetic element of the serial adder.
//   A, B, Cin : operand bits and carry-in
//   S, Cout   : sum bit and carry-out
module one_bit (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: accepts {a,b,cin} over a valid/ready handshake,
// feeds one bit pair per clock (LSB first) through a single full-adder cell,
// and presents the registered {cout,sum} over a second valid/ready handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b, cin           : operands, sampled on in_valid & in_ready
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, cout           : registered result, held until the next result loads
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = CNT_W(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s;
    logic             w_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_sh_nxt;

    one_bit u_cell (
        .A    (r_a_sh[0]),
        .B    (r_b_sh[0]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));
    // New sum bit enters at the MSB; written as shifts so WIDTH=1 needs no special case.
    assign w_sum_sh_nxt = (r_sum_sh >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_a_sh  <= a;
                r_b_sh  <= b;
                r_carry <= cin;
                r_cnt   <= '0;
            end else if (r_state == SHIFT) begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_sum_sh <= w_sum_sh_nxt;
                r_carry  <= w_cout;
                r_cnt    <= r_cnt + CW'(1);
                if (w_last) begin
                    r_sum  <= w_sum_sh_nxt;
                    r_cout <= w_cout;
                end
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
    localparam int W4 = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          in_valid4 = 1'b0, in_ready4, cin4 = 1'b0, out_valid4, out_ready4 = 1'b0, cout4;
    logic [W4-1:0] a4 = '0, b4 = '0, sum4;

    logic          in_valid1 = 1'b0, in_ready1, cin1 = 1'b0, out_valid1, out_ready1 = 1'b0, cout1;
    logic [0:0]    a1 = '0, b1 = '0, sum1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition; low WIDTH bits are sum, bit WIDTH is cout.
    function automatic longint ref_add(input longint x, input longint y, input longint c);
        return x + y + c;
    endfunction

    // One full transaction on the WIDTH=4 instance, called at a negedge while idle.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input int hold, input bit junk);
        longint e;
        logic [3:0] s_exp;
        logic c_exp;
        e = ref_add(a, b, c);
        s_exp = e[3:0];
        c_exp = e[4];
        chk("op_ready_idle", in_ready4, 1'b1);
        a4 = a; b4 = b; cin4 = c; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        for (int i = 0; i < W4; i++) begin
            chk("shift_no_valid", out_valid4, 1'b0);
            chk("shift_not_ready", in_ready4, 1'b0);
            if (junk && i == 1) begin
                in_valid4 = 1'b1; a4 = 4'hA; b4 = 4'h6; cin4 = 1'b1;
            end else begin
                in_valid4 = 1'b0;
            end
            @(negedge clk);
        end
        in_valid4 = 1'b0;
        chk("done_valid", out_valid4, 1'b1);
        chk("done_sum", sum4, s_exp);
        chk("done_cout", cout4, c_exp);
        for (int h = 0; h < hold; h++) begin
            out_ready4 = 1'b0;
            if (junk) begin
                in_valid4 = 1'b1; a4 = 4'h3; b4 = 4'h9;
            end
            @(negedge clk);
            chk("hold_valid", out_valid4, 1'b1);
            chk("hold_not_ready", in_ready4, 1'b0);
            chk("hold_sum", sum4, s_exp);
            chk("hold_cout", cout4, c_exp);
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        chk("after_valid", out_valid4, 1'b0);
        chk("after_ready", in_ready4, 1'b1);
        chk("after_sum_kept", sum4, s_exp);
        chk("after_cout_kept", cout4, c_exp);
    endtask

    initial begin
        int acc_cyc[$];
        logic [1:0] exp_q[$];
        int cyc;
        bit first;
        logic [1:0] got;
        longint e;

        // Reset values while rst_n is held low.
        #1;
        chk("rst_ready", in_ready4, 1'b1);
        chk("rst_valid", out_valid4, 1'b0);
        chk("rst_sum", sum4, 4'd0);
        chk("rst_cout", cout4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready4, 1'b1);

        // Directed cases.
        op4(4'd5, 4'd3, 1'b0, 0, 1'b0);
        op4(4'd15, 4'd15, 1'b1, 0, 1'b0);
        op4(4'd15, 4'd1, 1'b0, 0, 1'b0);
        // Back-pressure with ignored in_valid pulses during SHIFT and DONE.
        op4(4'd9, 4'd4, 1'b1, 3, 1'b1);

        // Asynchronous reset between edges clears held outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sum", sum4, 4'd0);
        chk("async_rst_cout", cout4, 1'b0);
        chk("async_rst_ready", in_ready4, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort mid-SHIFT with carry set, then verify no stale carry.
        a4 = 4'd15; b4 = 4'd15; cin4 = 1'b1; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid4, 1'b0);
        chk("abort_ready", in_ready4, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_never_valid", out_valid4, 1'b0);
        end
        op4(4'd2, 4'd2, 1'b0, 0, 1'b0);

        // Randomized transactions.
        for (int t = 0; t < 10; t++) begin
            op4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // WIDTH=1: streaming with both handshakes always asserted.
        in_valid1 = 1'b1;
        out_ready1 = 1'b1;
        first = 1'b1;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (out_valid1 && out_ready1) begin
                if (exp_q.size() == 0) begin
                    chk("w1_unexpected_result", 1'b1, 1'b0);
                end else begin
                    got = exp_q.pop_front();
                    chk("w1_sum", sum1, got[0]);
                    chk("w1_cout", cout1, got[1]);
                end
            end
            if (first) begin
                a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
            end else begin
                a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
                cin1 = 1'($urandom_range(0, 1));
            end
            if (in_ready1) begin
                e = ref_add(a1, b1, cin1);
                exp_q.push_back(e[1:0]);
                acc_cyc.push_back(cyc);
                first = 1'b0;
            end
            @(negedge clk);
        end
        in_valid1 = 1'b0;
        // Drain: bounded wait for any outstanding result.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            if (out_valid1) begin
                got = exp_q.pop_front();
                chk("w1_drain_sum", sum1, got[0]);
                chk("w1_drain_cout", cout1, got[1]);
            end
            @(negedge clk);
        end
        chk("w1_all_results_seen", 64'(exp_q.size()), 64'd0);
        chk("w1_accept_count_ok", 64'(acc_cyc.size() >= 10), 64'd1);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            chk("w1_issue_interval", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "timeout");
    end
endmodule
